sif_uart_bridge: RTL
====================

# sif_uart_bridge

Debug bridge that masters the simple interface (`addr`/`re`/`we`/`wd`/`rd`) from a host serial link. It receives 8N1 command frames on `uart_rx`, performs one 32-bit read or write on the simple bus, and returns the status byte or read data on `uart_tx`. It sits in front of peripherals such as `uart` so that registers can be accessed from a host terminal without a CPU.

## Interface
- `BAUD_DIV`, 868: clock cycles per bit period (100 MHz / 115200); legal range ≥ 4.
- `ADDR_W`, 8: simple-bus address width; the host sends one address byte, zero-extended into `addr`.
- `TIMEOUT_BITS`, 32: idle bit periods allowed between bytes of one command before it is abandoned.
- `clk`  in  1  system clock.
- `rstn`  in  1  reset; one clock; reset is synchronous and active-low.
- `addr`  out  ADDR_W  bus address.
- `re`  out  1  read enable, single-cycle pulse.
- `we`  out  1  write enable, single-cycle pulse.
- `wd`  out  32  write data.
- `rd`  in  32  read data from the addressed slave.
- `uart_rx`  in  1  serial input (asynchronous, idle high).
- `uart_tx`  out  1  serial output (idle high).

## Operation
- Command protocol, bytes LSB-first on the wire:
  - `0x57` ('W'), addr, d0..d3 (little-endian) → one write, reply `0x4B` ('K').
  - `0x52` ('R'), addr → one read, reply r0..r3 (little-endian).
  - Any other first byte → reply `0x45` ('E'), back to IDLE.
- RX path:
  - `uart_rx` passes through a 2-flop synchroniser.
  - A falling edge starts the bit counter. The start bit is rechecked at BAUD_DIV/2; if it is high, it is a glitch and the receiver returns to idle.
  - Data bits are sampled at bit mid-points.
  - A stop bit sampled low is a framing error: the byte is dropped and the command FSM goes to IDLE.
- Command FSM states and transitions:
  - IDLE → GET_ADDR on 'W' or 'R'; IDLE → SEND on an unknown byte (loads 'E').
  - GET_ADDR → GET_DATA on 'W'; GET_ADDR → BUS_RD on 'R'.
  - GET_DATA collects 4 bytes with a counter 0..3, then → BUS_WR.
  - BUS_WR: one cycle, then → SEND ('K').
  - BUS_RD: one cycle, then → CAPTURE.
  - CAPTURE: latch `rd`, then → SEND (4 bytes).
  - SEND → IDLE after the last stop bit.
- Bytes completed on `uart_rx` while the FSM is in BUS_*/CAPTURE/SEND are discarded. The host must wait for the reply.
- Timeout: the counter clears on each received byte. If it reaches TIMEOUT_BITS × BAUD_DIV in GET_ADDR or GET_DATA, the FSM returns to IDLE with no bus access and no reply.
- `addr` and `wd` are loaded in GET_ADDR/GET_DATA. They hold their values after the access until the next command overwrites them.
- Reset mid-operation: all state returns to IDLE.
  - A partially sent TX frame is cut off and `uart_tx` goes high.
  - No `re`/`we` pulse is issued.

## Timing
- Reset values: `uart_tx`=1, `re`=0, `we`=0, `addr`=0, `wd`=0; FSM in IDLE; all counters 0.
- `we`: high for exactly the BUS_WR cycle, with `addr`/`wd` already stable in that cycle.
- `re`: high for exactly the BUS_RD cycle.
- `rd`: sampled in CAPTURE, one cycle after `re`, which matches the registered read of the simple-bus slaves.
- Reply start: the TX start bit begins the cycle after BUS_WR or CAPTURE (or after the unknown byte's stop-bit sample).
- TX frame: 10 × BAUD_DIV cycles. Multi-byte replies are sent back-to-back with no idle gap.
- RX byte-complete: asserted at the stop-bit mid-sample, i.e. 9.5 bit periods after the start edge, plus 2 cycles of synchroniser delay.

## Structure
- Package `sif_uart_bridge_pkg`:
  - Command byte constants: `CMD_WR`=0x57, `CMD_RD`=0x52, `RSP_OK`=0x4B, `RSP_ERR`=0x45.
  - FSM state enum.
- One sub-module, `uart_byte_phy`: baud counters, RX synchroniser/deserialiser (byte, valid, frame_err), and TX serialiser (byte, start, busy/done).
- The top level holds only the command FSM, the timeout counter, and the bus registers.

## Test plan
All scenarios use BAUD_DIV=8 and TIMEOUT_BITS=32.
- Reset: hold `rstn`=0 for 7 clocks → `uart_tx`=1, `re`=`we`=0, `addr`=0, `wd`=0.
- Write: send 57 04 78 56 34 12 → one `we` pulse with `addr`=0x04, `wd`=0x12345678; then `uart_tx` returns 0x4B.
- Read: send 52 08 with the slave model returning 0xCAFEBABE → one `re` pulse with `addr`=0x08; reply bytes BE BA FE CA, back-to-back.
- Error and framing: send 0x33 → reply 0x45 with no bus pulse. Send 'W' with its stop bit forced low → no reply; a following valid 'R' 00 completes normally.
- Timeout: send 57 10 AA, then idle 40 bit periods → no `we`, no reply. Then send 52 10 → normal read.
- Reset during reply: assert `rstn` mid-way through r1 → `uart_tx` is 1 on the cycle after reset is sampled; a subsequent command behaves normally.

Source files
------------

// File: rtl/sif_uart_bridge_pkg.sv
// Shared constants, state types and helpers for the serial-to-simple-bus debug bridge.
package sif_uart_bridge_pkg;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;

  typedef enum logic [2:0] {
    StIdle,
    StGetAddr,
    StGetData,
    StBusWr,
    StBusRd,
    StCapture,
    StSend
  } bridge_state_e;

  typedef enum logic [1:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop
  } rx_state_e;

  // Little-endian byte lane select of a 32-bit word.
  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] i);
    return w[{i, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/uart_byte_phy.sv
// 8N1 byte PHY: synchronised/deserialised receiver and back-to-back capable transmitter.
module uart_byte_phy
  import sif_uart_bridge_pkg::*;
#(
  parameter int unsigned BaudDiv = 868
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic [7:0] rx_byte_o,
  output logic       rx_valid_o,
  output logic       rx_frame_err_o,
  output logic       tx_o,
  input  logic [7:0] tx_byte_i,
  input  logic       tx_start_i,
  output logic       tx_done_o
);

  localparam int unsigned CntW = $clog2(BaudDiv);
  localparam logic [CntW-1:0] BitLast  = CntW'(BaudDiv - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(BaudDiv / 2 - 1);

  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e       rx_state_q, rx_state_d;
  logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;

  logic            tx_q, tx_d;
  logic            tx_busy_q, tx_busy_d;
  logic [9:0]      tx_shift_q, tx_shift_d;
  logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]      tx_bit_q, tx_bit_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      tx_q       <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_shift_q <= '1;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
    end else begin
      rx_meta_q  <= rx_i;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      tx_q       <= tx_d;
      tx_busy_q  <= tx_busy_d;
      tx_shift_q <= tx_shift_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
    end
  end

  always_comb begin
    rx_state_d     = rx_state_q;
    rx_cnt_d       = rx_cnt_q + CntW'(1);
    rx_bit_d       = rx_bit_q;
    rx_shift_d     = rx_shift_q;
    rx_valid_o     = 1'b0;
    rx_frame_err_o = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) rx_state_d = RxStart;
      end
      RxStart: begin
        // A start bit that is high again at its midpoint is a glitch.
        if (rx_cnt_q == HalfLast) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (rx_cnt_q == BitLast) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RxStop;
        end
      end
      RxStop: begin
        if (rx_cnt_q == BitLast) begin
          rx_cnt_d       = '0;
          rx_state_d     = RxIdle;
          rx_valid_o     = rx_sync_q;
          rx_frame_err_o = !rx_sync_q;
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  assign rx_byte_o = rx_shift_q;

  always_comb begin
    tx_busy_d  = tx_busy_q;
    tx_shift_d = tx_shift_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_done_o  = 1'b0;
    if (tx_busy_q) begin
      tx_cnt_d = tx_cnt_q + CntW'(1);
      if (tx_cnt_q == BitLast) begin
        tx_cnt_d   = '0;
        tx_shift_d = {1'b1, tx_shift_q[9:1]};
        tx_bit_d   = tx_bit_q + 4'd1;
        if (tx_bit_q == 4'd9) begin
          tx_done_o = 1'b1;
          tx_busy_d = 1'b0;
        end
      end
    end
    // A start in the final stop-bit cycle chains the next frame with no gap.
    if (tx_start_i && (!tx_busy_q || tx_done_o)) begin
      tx_busy_d  = 1'b1;
      tx_shift_d = {1'b1, tx_byte_i, 1'b0};
      tx_cnt_d   = '0;
      tx_bit_d   = '0;
    end
    tx_d = tx_busy_d ? tx_shift_d[0] : 1'b1;
  end

  assign tx_o = tx_q;

endmodule

// File: rtl/sif_uart_bridge.sv
// Host serial debug bridge: decodes 'W'/'R' command frames into single simple-bus accesses.
module sif_uart_bridge
  import sif_uart_bridge_pkg::*;
#(
  parameter int unsigned BAUD_DIV     = 868,
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned TIMEOUT_BITS = 32
) (
  input  logic              clk,
  input  logic              rstn,
  output logic [ADDR_W-1:0] addr,
  output logic              re,
  output logic              we,
  output logic [31:0]       wd,
  input  logic [31:0]       rd,
  input  logic              uart_rx,
  output logic              uart_tx
);

  localparam logic [31:0] TimeoutCycles = 32'(TIMEOUT_BITS * BAUD_DIV);

  bridge_state_e     state_q, state_d;
  logic              is_wr_q, is_wr_d;
  logic [1:0]        data_cnt_q, data_cnt_d;
  logic [1:0]        send_idx_q, send_idx_d;
  logic [1:0]        send_last_q, send_last_d;
  logic [31:0]       to_cnt_q, to_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wd_q, wd_d;
  logic [31:0]       rd_q, rd_d;

  logic [7:0] rx_byte;
  logic       rx_valid, rx_frame_err;
  logic [7:0] tx_byte;
  logic       tx_start, tx_done;

  uart_byte_phy #(
    .BaudDiv(BAUD_DIV)
  ) u_phy (
    .clk_i         (clk),
    .rst_ni        (rstn),
    .rx_i          (uart_rx),
    .rx_byte_o     (rx_byte),
    .rx_valid_o    (rx_valid),
    .rx_frame_err_o(rx_frame_err),
    .tx_o          (uart_tx),
    .tx_byte_i     (tx_byte),
    .tx_start_i    (tx_start),
    .tx_done_o     (tx_done)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= StIdle;
      is_wr_q     <= 1'b0;
      data_cnt_q  <= '0;
      send_idx_q  <= '0;
      send_last_q <= '0;
      to_cnt_q    <= '0;
      addr_q      <= '0;
      wd_q        <= '0;
      rd_q        <= '0;
    end else begin
      state_q     <= state_d;
      is_wr_q     <= is_wr_d;
      data_cnt_q  <= data_cnt_d;
      send_idx_q  <= send_idx_d;
      send_last_q <= send_last_d;
      to_cnt_q    <= to_cnt_d;
      addr_q      <= addr_d;
      wd_q        <= wd_d;
      rd_q        <= rd_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    is_wr_d     = is_wr_q;
    data_cnt_d  = data_cnt_q;
    send_idx_d  = send_idx_q;
    send_last_d = send_last_q;
    to_cnt_d    = '0;
    addr_d      = addr_q;
    wd_d        = wd_q;
    rd_d        = rd_q;
    tx_byte     = RSP_OK;
    tx_start    = 1'b0;
    re          = 1'b0;
    we          = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rx_valid) begin
          if (rx_byte == CMD_WR || rx_byte == CMD_RD) begin
            is_wr_d = (rx_byte == CMD_WR);
            state_d = StGetAddr;
          end else begin
            tx_byte     = RSP_ERR;
            tx_start    = 1'b1;
            send_idx_d  = '0;
            send_last_d = '0;
            state_d     = StSend;
          end
        end
      end
      StGetAddr, StGetData: begin
        to_cnt_d = to_cnt_q + 32'd1;
        if (rx_frame_err || to_cnt_q == TimeoutCycles) begin
          to_cnt_d = '0;
          state_d  = StIdle;
        end else if (rx_valid) begin
          to_cnt_d = '0;
          if (state_q == StGetAddr) begin
            addr_d     = ADDR_W'(rx_byte);
            data_cnt_d = '0;
            state_d    = is_wr_q ? StGetData : StBusRd;
          end else begin
            wd_d       = {rx_byte, wd_q[31:8]};
            data_cnt_d = data_cnt_q + 2'd1;
            if (data_cnt_q == 2'd3) state_d = StBusWr;
          end
        end
      end
      StBusWr: begin
        we          = 1'b1;
        tx_byte     = RSP_OK;
        tx_start    = 1'b1;
        send_idx_d  = '0;
        send_last_d = '0;
        state_d     = StSend;
      end
      StBusRd: begin
        re      = 1'b1;
        state_d = StCapture;
      end
      StCapture: begin
        rd_d        = rd;
        tx_byte     = rd[7:0];
        tx_start    = 1'b1;
        send_idx_d  = '0;
        send_last_d = 2'd3;
        state_d     = StSend;
      end
      StSend: begin
        if (tx_done) begin
          if (send_idx_q == send_last_q) begin
            state_d = StIdle;
          end else begin
            send_idx_d = send_idx_q + 2'd1;
            tx_byte    = byte_sel(rd_q, send_idx_q + 2'd1);
            tx_start   = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign addr = addr_q;
  assign wd   = wd_q;

endmodule
